// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - shared register-file write-back widths, source indices and helpers
package riscv_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int WB_NUM_REQ = 3;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_LSU = 2'd1,
    WB_SRC_CSR = 2'd2
  } wb_src_e;

  // Round-robin successor of a source index.
  function automatic int wb_next_idx(input int idx, input int num_req);
    return (idx + 1) % num_req;
  endfunction

endpackage

// File: rtl/wb_rr_grant.sv
// rtl/wb_rr_grant.sv - combinational round-robin pick: full vector + pointer -> one-hot grant and index
module wb_rr_grant #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] full,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int c;
    c         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Scan ptr, ptr+1, ... wrapping; first full buffer wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && full[c]) begin
        grant[c]  = 1'b1;
        grant_idx = PTR_W'(c);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port (option: WB_BYPASS_EN)
module regfile_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      RegWriteEn,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         data,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  input  logic [DATA_W-1:0]         rf_data_r1,
  input  logic [DATA_W-1:0]         rf_data_r2,
  output logic [DATA_W-1:0]         fwd_data_r1,
  output logic [DATA_W-1:0]         fwd_data_r2,
`endif
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] full;
  logic [ADDR_W-1:0]  buf_rd   [NUM_REQ];
  logic [DATA_W-1:0]  buf_data [NUM_REQ];
  logic [PTR_W-1:0]   ptr;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               do_grant;

  wb_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_grant (
    .full      (full),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign do_grant  = grant_any & ~wb_stall;
  assign req_ready = ~full;
  assign busy      = |full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full       <= '0;
      ptr        <= '0;
      RegWriteEn <= 1'b0;
      rd         <= '0;
      data       <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      RegWriteEn <= do_grant;
      if (do_grant) begin
        rd   <= buf_rd[grant_idx];
        data <= buf_data[grant_idx];
        ptr  <= PTR_W'(wb_next_idx(int'(grant_idx), NUM_REQ));
      end
      // Accept requires an empty buffer and drain requires a full one, so they never collide.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (do_grant && grant[i]) begin
          full[i] <= 1'b0;
        end else if (req_valid[i] && !full[i] && (req_rd[i*ADDR_W +: ADDR_W] != '0)) begin
          full[i]     <= 1'b1;
          buf_rd[i]   <= req_rd[i*ADDR_W +: ADDR_W];
          buf_data[i] <= req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  // x0 is hardwired zero, so a write to it must never be forwarded.
  assign fwd_data_r1 = (RegWriteEn && (rd == rs1_addr) && (rd != '0)) ? data : rf_data_r1;
  assign fwd_data_r2 = (RegWriteEn && (rd == rs2_addr) && (rd != '0)) ? data : rf_data_r2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter (optional WB_BYPASS_EN coverage)
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  logic            clk;
  logic            rst;
  logic            wb_stall;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_rd;
  logic [N*DW-1:0] req_data;
  logic            RegWriteEn;
  logic [AW-1:0]   rd;
  logic [DW-1:0]   data;
  logic            busy;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [DW-1:0]   rf_data_r1;
  logic [DW-1:0]   rf_data_r2;
  logic [DW-1:0]   fwd_data_r1;
  logic [DW-1:0]   fwd_data_r2;
`endif

  wb_t           exp_q[$];
  logic [DW-1:0] rf [32];
  int            n_pass;
  int            n_total;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wb_stall    (wb_stall),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .RegWriteEn  (RegWriteEn),
    .rd          (rd),
    .data        (data),
`ifdef WB_BYPASS_EN
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rf_data_r1  (rf_data_r1),
    .rf_data_r2  (rf_data_r2),
    .fwd_data_r1 (fwd_data_r1),
    .fwd_data_r2 (fwd_data_r2),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model fed by the DUT write port.
  always @(posedge clk) begin
    if (RegWriteEn) rf[rd] <= data;
  end

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    wb_t e;
    if (rst && RegWriteEn) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_unexpected: got rd=%0d data=%0h, required no write", rd, data);
      end else begin
        e = exp_q.pop_front();
        if (rd !== e.rd || data !== e.data)
          $display("FAIL wb_write: got rd=%0d data=%0h, required rd=%0d data=%0h", rd, data, e.rd, e.data);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
    else n_pass++;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_rd[i*AW +: AW]   = r;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic expect_wb(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wb_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass    = 0;
    n_total   = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst       = 1'b0;
    wb_stall  = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
`ifdef WB_BYPASS_EN
    rs1_addr   = '0;
    rs2_addr   = '0;
    rf_data_r1 = '0;
    rf_data_r2 = '0;
`endif
    tick();
    tick();
    chk("rst_wen",   64'(RegWriteEn), 64'd0);
    chk("rst_rd",    64'(rd),         64'd0);
    chk("rst_data",  64'(data),       64'd0);
    chk("rst_ready", 64'(req_ready),  64'b111);
    chk("rst_busy",  64'(busy),       64'd0);
    rst = 1'b1;
    tick();

    // Single ALU write, uncontended.
    req_valid = 3'b001;
    set_req(0, 5'd3, 32'd45);
    expect_wb(5'd3, 32'd45);
    tick();
    req_valid = '0;
    chk("t2_busy", 64'(busy), 64'd1);
    tick();
    chk("t2_wen", 64'(RegWriteEn), 64'd1);
    chk("t2_rd",  64'(rd),         64'd3);
    tick();
    chk("t2_wen_drop", 64'(RegWriteEn), 64'd0);
    chk("t2_rf_x3",    64'(rf[3]),      64'd45);

    // Fill all buffers under stall, then reset them away.
    wb_stall  = 1'b1;
    req_valid = 3'b111;
    set_req(0, 5'd7, 32'd70);
    set_req(1, 5'd8, 32'd80);
    set_req(2, 5'd9, 32'd90);
    tick();
    req_valid = '0;
    chk("t1_ready_full", 64'(req_ready), 64'b000);
    chk("t1_busy_full",  64'(busy),      64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t1_wen",   64'(RegWriteEn), 64'd0);
    chk("t1_rd",    64'(rd),         64'd0);
    chk("t1_data",  64'(data),       64'd0);
    chk("t1_ready", 64'(req_ready),  64'b111);
    tick();
    rst      = 1'b1;
    wb_stall = 1'b0;
    repeat (4) tick();
    chk("t1_rf_x7", 64'(rf[7]), 64'd0);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Three-way contention from ptr=0, twice to confirm the pointer wraps back to 0.
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'd10);
    set_req(1, 5'd2, 32'd20);
    set_req(2, 5'd3, 32'd30);
    expect_wb(5'd1, 32'd10);
    expect_wb(5'd2, 32'd20);
    expect_wb(5'd3, 32'd30);
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("t3_rf_x2", 64'(rf[2]), 64'd20);
    req_valid = 3'b111;
    set_req(0, 5'd11, 32'hA);
    set_req(1, 5'd12, 32'hB);
    set_req(2, 5'd13, 32'hC);
    expect_wb(5'd11, 32'hA);
    expect_wb(5'd12, 32'hB);
    expect_wb(5'd13, 32'hC);
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("t3_q_drained", 64'(exp_q.size()), 64'd0);

    // rd==0 from LSU is dropped.
    req_valid = 3'b010;
    set_req(1, 5'd0, 32'd99);
    tick();
    req_valid = '0;
    chk("t4_ready", 64'(req_ready), 64'b111);
    chk("t4_busy",  64'(busy),      64'd0);
    repeat (3) tick();

    // Stall holds a buffered ALU write.
    wb_stall  = 1'b1;
    req_valid = 3'b001;
    set_req(0, 5'd4, 32'd55);
    tick();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      chk("t5_busy_stall", 64'(busy),       64'd1);
      chk("t5_wen_stall",  64'(RegWriteEn), 64'd0);
      tick();
    end
    expect_wb(5'd4, 32'd55);
    wb_stall = 1'b0;
    tick();
    chk("t5_wen",  64'(RegWriteEn), 64'd1);
    chk("t5_busy", 64'(busy),       64'd0);
    tick();

`ifdef WB_BYPASS_EN
    req_valid = 3'b001;
    set_req(0, 5'd5, 32'd7);
    expect_wb(5'd5, 32'd7);
    tick();
    req_valid = '0;
    tick();
    rs1_addr   = 5'd5;
    rf_data_r1 = 32'd0;
    rs2_addr   = 5'd0;
    rf_data_r2 = 32'h1234;
    #1;
    chk("t6_fwd_r1", 64'(fwd_data_r1), 64'd7);
    chk("t6_fwd_r2", 64'(fwd_data_r2), 64'h1234);
    rs1_addr   = 5'd6;
    rf_data_r1 = 32'h5A5A;
    #1;
    chk("t6_fwd_r1_miss", 64'(fwd_data_r1), 64'h5A5A);
    tick();
`endif

    repeat (3) tick();
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
